alu_mc: RTL and testbench

Parametrised, registered successor to the combinational MIPS ALU: same opcode map and flag semantics, generalised to `N`-bit operands, with a valid/ready handshake on both sides and a new multi-cycle unsigned multiply. It sits between the decode/operand-fetch stage and writeback in the multi-cycle MIPS datapath. Single-cycle ops issue back-to-back; `MUL` stalls the input for `N` cycles.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_mc.sv | 139 +++++++++++++
 tb/tb_alu_mc.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered multi-cycle ALU: opcode map,
// controller states and the opcode legality check.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_NOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SLL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  // Opcode 4 is a hole in the map; everything above MUL is reserved too.
  function automatic logic op_is_valid(input logic [3:0] op);
    return (op <= OP_MUL) && (op != 4'd4);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// N clocks per product, result presented combinationally on the done cycle.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   X,
  input  logic [N-1:0]   Y,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam int CW = $clog2(N);

  logic           busy;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc_next;

  // prod is the accumulator after this cycle's step, so it carries the full
  // product during the done cycle and the caller can latch it on that edge.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = busy && (cnt == '0);
  assign prod     = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(N - 1);
      acc    <= '0;
      mcand  <= {{N{1'b0}}, X};
      mplier <= Y;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) busy <= 1'b0;
      else      cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered N-bit MIPS ALU with valid/ready on both sides; single-cycle ops
// stream back-to-back, MUL runs the iterative multiplier for N clocks.
module alu_mc
  import alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic [3:0]   op_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic         overflow,
  output logic         equal,
  output logic         zero
);

  state_t state;

  logic signed [N-1:0] xs;
  logic signed [N-1:0] ys;
  logic [SHW-1:0]      sh;
  logic [N-1:0]        sum;
  logic [N-1:0]        diff;
  logic [N-1:0]        z_c;
  logic                ovf_c;
  logic                eq_c;
  logic                zero_c;
  logic                accept;
  logic                is_mul;
  logic                mul_start;
  logic                mul_done;
  logic [2*N-1:0]      mul_prod;
  logic                eq_pend;

  assign xs = $signed(X);
  assign ys = $signed(Y);
  assign sh = X[SHW-1:0];

  always_comb begin
    sum   = X + Y;
    diff  = X - Y;
    z_c   = '0;
    ovf_c = 1'b0;
    case (op_code)
      OP_AND: z_c = X & Y;
      OP_OR:  z_c = X | Y;
      OP_XOR: z_c = X ^ Y;
      OP_NOR: z_c = ~(X | Y);
      OP_ADD: begin
        z_c   = sum;
        ovf_c = (X[N-1] == Y[N-1]) && (sum[N-1] != X[N-1]);
      end
      OP_SUB: begin
        z_c   = diff;
        ovf_c = (X[N-1] != Y[N-1]) && (diff[N-1] != X[N-1]);
      end
      OP_SLT: z_c = {{(N-1){1'b0}}, (xs < ys)};
      OP_SRL: z_c = Y >> sh;
      OP_SLL: z_c = Y << sh;
      OP_SRA: z_c = $unsigned(ys >>> sh);
      default: z_c = '0;
    endcase
    // Reserved opcodes force every flag low, including zero despite Z == 0.
    eq_c   = op_is_valid(op_code) && (diff == '0);
    zero_c = op_is_valid(op_code) && (z_c == '0);
  end

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op_code == OP_MUL);
  assign mul_start = accept && is_mul;

  alu_mul_iter #(.N(N)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .X     (X),
    .Y     (Y),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      Z         <= '0;
      overflow  <= 1'b0;
      equal     <= 1'b0;
      zero      <= 1'b0;
      eq_pend   <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (state == HOLD && !out_ready) begin
            state <= HOLD;
          end else if (accept && is_mul) begin
            // equal is taken from the operands now; they are gone by done.
            state     <= RUN;
            out_valid <= 1'b0;
            eq_pend   <= (diff == '0);
          end else if (accept) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            Z         <= z_c;
            overflow  <= ovf_c;
            equal     <= eq_c;
            zero      <= zero_c;
          end else begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        RUN: begin
          if (mul_done) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            Z         <= mul_prod[N-1:0];
            overflow  <= (mul_prod[2*N-1:N] != '0);
            equal     <= eq_pend;
            zero      <= (mul_prod[N-1:0] == '0);
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed scenarios followed by random operations, all
// compared with an arithmetic reference model of the opcode rules.
module tb_alu_mc;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic [3:0]   op_code;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Z;
  logic         overflow;
  logic         equal;
  logic         zero;

  int total = 0;
  int bad   = 0;

  alu_mc #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .op_code   (op_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .overflow  (overflow),
    .equal     (equal),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed results computed in 64-bit integers, overflow by range.
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] z, output logic ovf,
                                output logic eq, output logic zr);
    longint sx;
    longint sy;
    longint r;
    logic [63:0] p;
    int sh;
    logic ok;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    sh  = int'(x % 32);
    z   = 32'd0;
    ovf = 1'b0;
    ok  = 1'b1;
    case (op)
      4'd0: z = x & y;
      4'd1: z = x | y;
      4'd2: z = x ^ y;
      4'd3: z = ~(x | y);
      4'd5: begin r = sx + sy; z = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd6: begin r = sx - sy; z = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd7: z = (sx < sy) ? 32'd1 : 32'd0;
      4'd8: z = y >> sh;
      4'd9: z = y << sh;
      4'd10: begin r = sy >>> sh; z = r[31:0]; end
      4'd11: begin p = {32'd0, x} * {32'd0, y}; z = p[31:0]; ovf = (p[63:32] != 32'd0); end
      default: ok = 1'b0;
    endcase
    eq = ok && (x == y);
    zr = ok && (z == 32'd0);
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op_code  = op;
    X        = x;
    Y        = y;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
    chk("issue.in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    X        = $urandom;
    Y        = $urandom;
    op_code  = 4'($urandom);
  endtask

  task automatic wait_result(output int lat, output int ir_low);
    lat    = 0;
    ir_low = (!in_ready) ? 1 : 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (!in_ready) ir_low++;
    end
  endtask

  task automatic run_check(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int lat;
    int ir_low;
    logic [31:0] ez;
    logic eo, ee, ezr;
    issue(op, x, y);
    wait_result(lat, ir_low);
    model(op, x, y, ez, eo, ee, ezr);
    chk({tag, ".latency"}, lat, (op == 4'd11) ? 32 : 0);
    chk({tag, ".ready_low"}, ir_low, (op == 4'd11) ? 32 : 0);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".Z"}, Z, ez);
    chk({tag, ".overflow"}, overflow, eo);
    chk({tag, ".equal"}, equal, ee);
    chk({tag, ".zero"}, zero, ezr);
  endtask

  logic [31:0] specials [4];
  logic [31:0] zs;
  logic        os, es, zrs;
  int          seen;

  initial begin
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h7FFF_FFFF;
    specials[2] = 32'h8000_0000;
    specials[3] = 32'hFFFF_FFFF;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    X         = '0;
    Y         = '0;
    op_code   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.Z", Z, 0);
    chk("rst.flags", {overflow, equal, zero}, 0);
    chk("rst.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // signed overflow on ADD
    run_check("add_ovf", 4'd5, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf.Zc", Z, 32'h8000_0000);
    chk("add_ovf.flagsc", {overflow, equal, zero}, 3'b100);

    run_check("sub_eq", 4'd6, 32'h1234_5678, 32'h1234_5678);
    chk("sub_eq.flagsc", {Z == 0, overflow, equal, zero}, 4'b1011);
    run_check("sra", 4'd10, 32'd4, 32'h8000_0000);
    chk("sra.Zc", Z, 32'hF800_0000);

    // back-to-back single-cycle ops
    @(negedge clk);
    in_valid = 1'b1;
    op_code  = 4'd0;
    X        = 32'hF0F0_A5A5;
    Y        = 32'h0FF0_FFFF;
    @(posedge clk); #1;
    chk("b2b.and.valid", out_valid, 1);
    chk("b2b.and.Z", Z, 32'h00F0_A5A5);
    @(negedge clk);
    op_code = 4'd1;
    @(posedge clk); #1;
    chk("b2b.or.valid", out_valid, 1);
    chk("b2b.or.Z", Z, 32'hFFF0_FFFF);
    @(negedge clk);
    op_code = 4'd7;
    X       = 32'hFFFF_FFFF;
    Y       = 32'd1;
    @(posedge clk); #1;
    chk("b2b.slt.valid", out_valid, 1);
    chk("b2b.slt.Z", Z, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;

    run_check("mul_hi", 4'd11, 32'h0001_0000, 32'h0001_0000);
    chk("mul_hi.flagsc", {Z == 0, overflow, zero}, 3'b111);
    run_check("mul_42", 4'd11, 32'd7, 32'd6);
    chk("mul_42.Zc", Z, 32'd42);

    // backpressure: result frozen while a pending op waits
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    issue(4'd2, 32'hDEAD_BEEF, 32'h1234_5678);
    model(4'd2, 32'hDEAD_BEEF, 32'h1234_5678, zs, os, es, zrs);
    @(negedge clk);
    in_valid = 1'b1;
    op_code  = 4'd5;
    X        = 32'd1;
    Y        = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.valid", out_valid, 1);
      chk("bp.in_ready", in_ready, 0);
      chk("bp.Z", Z, zs);
      chk("bp.flags", {overflow, equal, zero}, {os, es, zrs});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.next.valid", out_valid, 1);
    chk("bp.next.Z", Z, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;

    run_check("op4", 4'd4, 32'd0, 32'd0);
    chk("op4.allc", {Z, overflow, equal, zero}, 35'd0);

    // reset in the middle of a multiply
    issue(4'd11, 32'd7, 32'd6);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmul.out_valid", out_valid, 0);
    chk("rstmul.Z", Z, 0);
    chk("rstmul.flags", {overflow, equal, zero}, 0);
    chk("rstmul.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rstmul.no_pulse", seen, 0);
    run_check("rstmul.recover", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // random operations
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      op = 4'($urandom_range(0, 15));
      x  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
      y  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
      if ($urandom_range(0, 5) == 0) y = x;
      run_check("rand", op, x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
